metronome_array: RTL and testbench
==================================

# metronome_array

Multi-channel, runtime-configurable beat sequencer for the bit-serial PE datapath, and the parametrised successor to the single-channel metronome. It tracks CHANNELS independent serial lanes on fast_clk and counts valid beats into frames of a programmable length (1..BITWIDTH). Per lane, it flags the first and last beat of each frame, pulses a registered frame-complete strobe, and supports per-lane abort. It sits between the device-side valid sources and the PE array's word-assembly logic.

## Interface
Parameters:
- BITWIDTH, 8: maximum frame length in beats; also the reset frame length.
- CHANNELS, 4: number of independent lanes.
- CNT_W, clog2(BITWIDTH+1): width of cfg_len and each beat index.

Ports:
- fast_clk  in  1  sole clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- cfg_len  in  CNT_W  requested frame length.
- cfg_we  in  1  config write strobe.
- device_data_in_valid  in  CHANNELS  per-lane beat valid.
- abort  in  CHANNELS  per-lane frame abort.
- data_in_valid  out  CHANNELS  combinational; the current beat is beat 0 of a frame.
- data_last  out  CHANNELS  combinational; the current beat is the final beat of a frame.
- data_out_valid  out  CHANNELS  registered one-cycle frame-complete strobe.
- busy  out  CHANNELS  the lane is mid-frame (beat index != 0).
- beat_idx  out  CHANNELS*CNT_W  per-lane beat index; lane i occupies bits [i*CNT_W +: CNT_W].
- all_done  out  1  registered; every lane completed a frame in the same cycle.
- cfg_err  out  1  sticky config-rejection flag.

## Operation
- Reset (rst=1 at an edge) sets the following. Frame length len_r = BITWIDTH. Every beat_idx = 0. data_out_valid, busy, all_done and cfg_err are all 0. While rst is high, data_in_valid and data_last are forced to 0.
- Per lane i, with v = device_data_in_valid[i] and a = abort[i], update priority is:
  - a=1: the index goes to 0 and the beat, if any, is discarded. No data_out_valid is generated.
  - v=1 and idx == len_r-1: the index goes to 0 and data_out_valid[i]=1 in the next cycle.
  - v=1 otherwise: the index increments by 1.
  - v=0: the index holds.
- data_in_valid[i] = v & ~a & (idx==0).
- data_last[i] = v & ~a & (idx==len_r-1).
- busy[i] = (idx != 0), decoded from the register.
- len_r=1: every accepted beat is both first and last, the index stays 0, and data_out_valid pulses for each beat.
- Config write (cfg_we=1) is accepted only when all three hold:
  - 1 <= cfg_len <= BITWIDTH;
  - no lane is busy;
  - no lane has v=1 in the same cycle.
  An accepted write updates len_r at the edge; the new length governs beats from the next cycle onward.
- A rejected write leaves len_r unchanged and sets cfg_err. cfg_err is cleared only by rst.
- all_done is registered and equals the AND of the next-cycle data_out_valid bits across all lanes. With CHANNELS=1 it mirrors data_out_valid.
- Lanes are fully independent. Abort on one lane never affects another lane.
- Index arithmetic is CNT_W-bit unsigned. The index never exceeds len_r-1, so no wrap beyond the frame occurs.

## Timing
- Each lane is a two-state machine: IDLE (idx==0) and RUN (idx in 1..len_r-1).
  - IDLE goes to RUN on an accepted beat when len_r > 1.
  - RUN goes to IDLE on the last beat or on abort.
- data_in_valid and data_last have zero latency: they are combinational in the beat cycle.
- data_out_valid is asserted in the cycle after the last beat is accepted, for exactly one cycle.
- Back-to-back frames are supported with no gap. The beat after a last beat is beat 0 of the next frame, so data_in_valid=1 in that cycle.
- Abort while idle is a no-op for the index, and any simultaneous beat is still discarded.
- Asserting rst mid-frame discards partial frames. No data_out_valid pulse is emitted for them. The first cycle after rst deasserts behaves as IDLE with len_r = BITWIDTH.

## Test plan
- **Reset and default length.** Hold rst for 2 cycles, then apply 8 consecutive valid beats on lane 0.
  - data_in_valid[0] is 1 on beat 0 only.
  - data_last[0] is 1 on beat 7.
  - data_out_valid[0] is 1 exactly one cycle after beat 7.
  - all other lanes stay idle and all_done=0.
- **Runtime length with gaps.** Write cfg_len=3 while idle (expect cfg_err=0), then send 6 beats with valid gaps.
  - Two frames complete and data_out_valid pulses twice.
  - beat_idx follows 0,1,2,0,1,2 and holds during gaps.
- **Rejected configuration.** Write cfg_len=5 while lane 2 is at idx=1, then write cfg_len=0 while idle.
  - Both writes are rejected, len_r is unchanged and cfg_err=1.
  - cfg_err stays 1 until rst.
- **Abort.** With len=4, lane 1 receives 2 beats, then abort=1 together with valid=1.
  - The index goes to 0 and no data_out_valid is generated.
  - The next beat has data_in_valid[1]=1.
- **All lanes in lockstep.** With len=1, drive all 4 lanes valid for 3 cycles.
  - data_in_valid and data_last are 1 on every beat.
  - data_out_valid=4'b1111 and all_done=1 for 3 cycles, each lagging its beat by one cycle.
- **Reset mid-frame.** Assert rst with lane 3 at idx=6 (len 8).
  - No data_out_valid pulse.
  - After release, the next beat has data_in_valid[3]=1.

Source files
------------

// File: rtl/metronome_array.sv
`default_nettype none
// ============================================================================
// Module   : metronome_array
// Brief    : Per-lane beat sequencer. Counts valid beats into frames of a
//            runtime-programmable length, with first/last flags and abort.
// Revision : 1.0
// ============================================================================
module metronome_array #(
    parameter int BITWIDTH = 8,
    parameter int CHANNELS = 4,
    parameter int CNT_W    = $clog2(BITWIDTH + 1)
) (
    input  logic                      fast_clk,
    input  logic                      rst,
    input  logic [CNT_W-1:0]          cfg_len,
    input  logic                      cfg_we,
    input  logic [CHANNELS-1:0]       device_data_in_valid,
    input  logic [CHANNELS-1:0]       abort,
    output logic [CHANNELS-1:0]       data_in_valid,
    output logic [CHANNELS-1:0]       data_last,
    output logic [CHANNELS-1:0]       data_out_valid,
    output logic [CHANNELS-1:0]       busy,
    output logic [CHANNELS*CNT_W-1:0] beat_idx,
    output logic                      all_done,
    output logic                      cfg_err
);

    localparam logic [CNT_W-1:0] c_LEN_MAX = CNT_W'(BITWIDTH);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } lane_state_e;

    logic [CNT_W-1:0]    len_q;
    logic [CNT_W-1:0]    len_last_w;
    logic [CHANNELS-1:0] dov_d;
    logic [CHANNELS-1:0] dov_q;
    logic                all_done_q;
    logic                cfg_err_q;
    logic                cfg_ok_w;

    assign len_last_w = len_q - 1'b1;

    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_lane
            logic [CNT_W-1:0] idx_q;
            logic [CNT_W-1:0] idx_d;
            lane_state_e      state_w;
            logic             take_w;
            logic             last_w;

            // Lane state is implied by the index: zero means between frames.
            assign state_w = (idx_q != '0) ? ST_RUN : ST_IDLE;
            assign take_w  = device_data_in_valid[gi] & ~abort[gi];
            assign last_w  = (idx_q == len_last_w);

            always_comb begin
                idx_d = idx_q;
                if (abort[gi]) begin
                    idx_d = '0;
                end else if (device_data_in_valid[gi]) begin
                    idx_d = last_w ? '0 : idx_q + 1'b1;
                end
            end

            assign dov_d[gi]                     = take_w & last_w;
            assign data_in_valid[gi]             = ~rst & take_w & (state_w == ST_IDLE);
            assign data_last[gi]                 = ~rst & take_w & last_w;
            assign busy[gi]                      = (state_w == ST_RUN);
            assign beat_idx[gi*CNT_W +: CNT_W]   = idx_q;

            always_ff @(posedge fast_clk) begin
                if (rst) begin
                    idx_q <= '0;
                end else begin
                    idx_q <= idx_d;
                end
            end
        end
    endgenerate

    // Length may only change between frames on every lane, with no beat in flight.
    assign cfg_ok_w = (cfg_len != '0) && (cfg_len <= c_LEN_MAX) &&
                      ~|busy && ~|device_data_in_valid;

    always_ff @(posedge fast_clk) begin
        if (rst) begin
            len_q      <= c_LEN_MAX;
            dov_q      <= '0;
            all_done_q <= 1'b0;
            cfg_err_q  <= 1'b0;
        end else begin
            dov_q      <= dov_d;
            all_done_q <= &dov_d;
            if (cfg_we) begin
                if (cfg_ok_w) begin
                    len_q <= cfg_len;
                end else begin
                    cfg_err_q <= 1'b1;
                end
            end
        end
    end

    assign data_out_valid = dov_q;
    assign all_done       = all_done_q;
    assign cfg_err        = cfg_err_q;

endmodule
`default_nettype wire

// File: tb/tb_metronome_array.sv
`default_nettype none
// ============================================================================
// Module   : tb_metronome_array
// Brief    : Directed scenarios plus random traffic against a frame-level model.
// Revision : 1.0
// ============================================================================
module tb_metronome_array;

    localparam int BITWIDTH = 8;
    localparam int CHANNELS = 4;
    localparam int CNT_W    = 4;

    logic                      fast_clk = 1'b0;
    logic                      rst;
    logic [CNT_W-1:0]          cfg_len;
    logic                      cfg_we;
    logic [CHANNELS-1:0]       device_data_in_valid;
    logic [CHANNELS-1:0]       abort;
    logic [CHANNELS-1:0]       data_in_valid;
    logic [CHANNELS-1:0]       data_last;
    logic [CHANNELS-1:0]       data_out_valid;
    logic [CHANNELS-1:0]       busy;
    logic [CHANNELS*CNT_W-1:0] beat_idx;
    logic                      all_done;
    logic                      cfg_err;

    metronome_array #(
        .BITWIDTH(BITWIDTH),
        .CHANNELS(CHANNELS),
        .CNT_W   (CNT_W)
    ) u_dut (
        .fast_clk            (fast_clk),
        .rst                 (rst),
        .cfg_len             (cfg_len),
        .cfg_we              (cfg_we),
        .device_data_in_valid(device_data_in_valid),
        .abort               (abort),
        .data_in_valid       (data_in_valid),
        .data_last           (data_last),
        .data_out_valid      (data_out_valid),
        .busy                (busy),
        .beat_idx            (beat_idx),
        .all_done            (all_done),
        .cfg_err             (cfg_err)
    );

    always #5 fast_clk = ~fast_clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: frame length and position within the current frame per lane.
    int       m_len;
    int       m_pos [CHANNELS];
    bit [3:0] m_dov;
    bit       m_all;
    bit       m_err;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_len = BITWIDTH;
        for (int i = 0; i < CHANNELS; i++) m_pos[i] = 0;
        m_dov = '0;
        m_all = 1'b0;
        m_err = 1'b0;
    endtask

    // One cycle: drive at the falling edge, check, then advance the model past the next rise.
    task automatic step(input logic [3:0] v, input logic [3:0] a, input logic we,
                        input logic [3:0] len_in, input logic r);
        logic [3:0]  e_first;
        logic [3:0]  e_last;
        logic [3:0]  e_busy;
        logic [15:0] e_idx;
        bit          any_busy;
        @(negedge fast_clk);
        rst                  = r;
        device_data_in_valid = v;
        abort                = a;
        cfg_we               = we;
        cfg_len              = len_in;
        #1;
        any_busy = 1'b0;
        for (int i = 0; i < CHANNELS; i++) begin
            e_first[i]       = !r && v[i] && !a[i] && (m_pos[i] == 0);
            e_last[i]        = !r && v[i] && !a[i] && (m_pos[i] == m_len - 1);
            e_busy[i]        = (m_pos[i] != 0);
            e_idx[i*4 +: 4]  = 4'(m_pos[i]);
            if (m_pos[i] != 0) any_busy = 1'b1;
        end
        check("data_in_valid",  32'(data_in_valid),  32'(e_first));
        check("data_last",      32'(data_last),      32'(e_last));
        check("busy",           32'(busy),           32'(e_busy));
        check("beat_idx",       32'(beat_idx),       32'(e_idx));
        check("data_out_valid", 32'(data_out_valid), 32'(m_dov));
        check("all_done",       32'(all_done),       32'(m_all));
        check("cfg_err",        32'(cfg_err),        32'(m_err));
        if (r) begin
            model_reset();
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                m_dov[i] = 1'b0;
                if (a[i]) begin
                    m_pos[i] = 0;
                end else if (v[i]) begin
                    if (m_pos[i] == m_len - 1) begin
                        m_pos[i] = 0;
                        m_dov[i] = 1'b1;
                    end else begin
                        m_pos[i] = m_pos[i] + 1;
                    end
                end
            end
            m_all = (m_dov == 4'hF);
            if (we) begin
                if (len_in >= 1 && len_in <= BITWIDTH && !any_busy && v == 4'h0)
                    m_len = int'(len_in);
                else
                    m_err = 1'b1;
            end
        end
    endtask

    initial begin
        rst                  = 1'b1;
        cfg_len              = '0;
        cfg_we               = 1'b0;
        device_data_in_valid = '0;
        abort                = '0;
        repeat (2) @(posedge fast_clk);
        model_reset();

        // Default length: eight beats on lane 0, then the completion strobe.
        for (int k = 0; k < 8; k++) step(4'h1, 4'h0, 1'b0, 4'd0, 1'b0);
        step(4'h0, 4'h0, 1'b0, 4'd0, 1'b0);
        step(4'h0, 4'h0, 1'b0, 4'd0, 1'b0);

        // Length 3 with gaps between beats.
        step(4'h0, 4'h0, 1'b1, 4'd3, 1'b0);
        for (int k = 0; k < 12; k++) step((k % 2 == 0) ? 4'h1 : 4'h0, 4'h0, 1'b0, 4'd0, 1'b0);
        step(4'h0, 4'h0, 1'b0, 4'd0, 1'b0);

        // Rejections: busy lane 2, then zero length while idle.
        step(4'h4, 4'h0, 1'b0, 4'd0, 1'b0);
        step(4'h0, 4'h0, 1'b1, 4'd5, 1'b0);
        step(4'h4, 4'h0, 1'b0, 4'd0, 1'b0);
        step(4'h4, 4'h0, 1'b0, 4'd0, 1'b0);
        step(4'h0, 4'h0, 1'b1, 4'd0, 1'b0);
        step(4'h1, 4'h0, 1'b0, 4'd0, 1'b0);
        step(4'h0, 4'h0, 1'b0, 4'd0, 1'b1);

        // Abort with a simultaneous beat on lane 1 at length 4.
        step(4'h0, 4'h0, 1'b1, 4'd4, 1'b0);
        step(4'h2, 4'h0, 1'b0, 4'd0, 1'b0);
        step(4'h2, 4'h0, 1'b0, 4'd0, 1'b0);
        step(4'h2, 4'h2, 1'b0, 4'd0, 1'b0);
        step(4'h0, 4'h0, 1'b0, 4'd0, 1'b0);
        for (int k = 0; k < 4; k++) step(4'h2, 4'h0, 1'b0, 4'd0, 1'b0);
        step(4'h0, 4'h0, 1'b0, 4'd0, 1'b0);

        // Length 1: all lanes in lockstep.
        step(4'h0, 4'h0, 1'b1, 4'd1, 1'b0);
        for (int k = 0; k < 3; k++) step(4'hF, 4'h0, 1'b0, 4'd0, 1'b0);
        step(4'h0, 4'h0, 1'b0, 4'd0, 1'b0);
        step(4'h0, 4'h0, 1'b0, 4'd0, 1'b0);

        // Reset with lane 3 mid-frame at length 8.
        step(4'h0, 4'h0, 1'b0, 4'd0, 1'b1);
        for (int k = 0; k < 6; k++) step(4'h8, 4'h0, 1'b0, 4'd0, 1'b0);
        step(4'h8, 4'h0, 1'b0, 4'd0, 1'b1);
        step(4'h0, 4'h0, 1'b0, 4'd0, 1'b0);
        step(4'h8, 4'h0, 1'b0, 4'd0, 1'b0);
        step(4'h0, 4'h0, 1'b0, 4'd0, 1'b0);

        // Random traffic: sparse aborts, config writes and resets.
        for (int k = 0; k < 600; k++) begin
            logic [3:0] rv;
            logic [3:0] ra;
            rv = 4'($urandom_range(0, 15));
            if (k % 50 < 10) rv = 4'h0;
            ra = 4'h0;
            for (int i = 0; i < CHANNELS; i++) ra[i] = ($urandom_range(0, 9) == 0);
            step(rv, ra, ($urandom_range(0, 7) == 0), 4'($urandom_range(0, 15)),
                 ($urandom_range(0, 99) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
